// File: rtl/epp_pkg.sv
// Shared types and constants for the host-side EPP engine.
package epp_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_SETUP   = 3'd1,
        ST_STROBE  = 3'd2,
        ST_RELEASE = 3'd3,
        ST_DONE    = 3'd4,
        ST_ABORT   = 3'd5
    } epp_state_e;

    // Bus levels while no cycle is in flight: strobes deasserted, EppWr in read.
    localparam logic STB_IDLE = 1'b1;
    localparam logic WR_IDLE  = 1'b1;

    localparam int DEFAULT_SETUP_CYC   = 2;
    localparam int DEFAULT_TIMEOUT_CYC = 1023;

endpackage

// File: rtl/epp_sync.sv
// Two-flop synchronizer for the asynchronous EppWait handshake input.
module epp_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/epp_host.sv
// Host-side EPP initiator: one address/data cycle per command, full four-phase EppWait handshake.
// Optional handshake watchdog enabled by defining EPP_HOST_TIMEOUT_EN.
//
// state   | meaning
// IDLE    | cmd_ready high, waiting for a command
// SETUP   | EppWr/DB driven, strobes high, counting setup cycles
// STROBE  | selected strobe low, waiting for synchronized Wait to rise
// RELEASE | strobe high, waiting for synchronized Wait to fall
// DONE    | rsp_valid pulse, bus released
// ABORT   | watchdog expired: rsp_valid + rsp_timeout pulse, bus released
module epp_host
    import epp_pkg::*;
#(
    parameter int SETUP_CYC   = DEFAULT_SETUP_CYC,
    parameter int TIMEOUT_CYC = DEFAULT_TIMEOUT_CYC
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic       cmd_addr,
    input  logic       cmd_wr,
    input  logic [7:0] cmd_data,
    output logic       rsp_valid,
    output logic [7:0] rsp_data,
    output logic       rsp_timeout,
    output logic       EppAstb,
    output logic       EppDstb,
    output logic       EppWr,
    input  logic       EppWait,
    output logic [7:0] db_o,
    output logic       db_oe,
    input  logic [7:0] db_i
);

    generate
        if (SETUP_CYC < 1 || SETUP_CYC > 15 || TIMEOUT_CYC < 1) begin : g_param_check
            $error("epp_host: SETUP_CYC must be 1..15 and TIMEOUT_CYC at least 1");
        end
    endgenerate

    localparam logic [3:0] SETUP_LOAD = 4'(SETUP_CYC);

    logic       wait_s;

    epp_state_e state_q;
    logic       is_addr_q;
    logic       is_wr_q;
    logic [7:0] data_q;
    logic [3:0] setup_cnt_q;

    logic       cmd_ready_q;
    logic       astb_q;
    logic       dstb_q;
    logic       eppwr_q;
    logic [7:0] db_o_q;
    logic       db_oe_q;
    logic       rsp_valid_q;
    logic [7:0] rsp_data_q;

`ifdef EPP_HOST_TIMEOUT_EN
    localparam int              TO_W    = $clog2(TIMEOUT_CYC + 1);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYC - 1);

    logic [TO_W-1:0] to_cnt_q;
    logic            rsp_timeout_q;
`endif

    epp_sync u_wait_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d_i   (EppWait),
        .q_o   (wait_s)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            is_addr_q   <= 1'b0;
            is_wr_q     <= 1'b0;
            data_q      <= '0;
            setup_cnt_q <= '0;
            cmd_ready_q <= 1'b1;
            astb_q      <= STB_IDLE;
            dstb_q      <= STB_IDLE;
            eppwr_q     <= WR_IDLE;
            db_o_q      <= '0;
            db_oe_q     <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
`ifdef EPP_HOST_TIMEOUT_EN
            to_cnt_q      <= '0;
            rsp_timeout_q <= 1'b0;
`endif
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (cmd_valid) begin
                        is_addr_q   <= cmd_addr;
                        is_wr_q     <= cmd_wr;
                        data_q      <= cmd_data;
                        setup_cnt_q <= SETUP_LOAD;
                        cmd_ready_q <= 1'b0;
                        state_q     <= ST_SETUP;
                    end
                end

                // First SETUP cycle drives the bus, so EppWr/DB lead the strobe by SETUP_CYC cycles.
                ST_SETUP: begin
                    eppwr_q <= ~is_wr_q;
                    db_oe_q <= is_wr_q;
                    db_o_q  <= data_q;
                    if (setup_cnt_q == 4'd0) begin
                        if (is_addr_q) begin
                            astb_q <= 1'b0;
                        end else begin
                            dstb_q <= 1'b0;
                        end
`ifdef EPP_HOST_TIMEOUT_EN
                        to_cnt_q <= '0;
`endif
                        state_q <= ST_STROBE;
                    end else begin
                        setup_cnt_q <= setup_cnt_q - 1'b1;
                    end
                end

                ST_STROBE: begin
                    if (wait_s) begin
                        rsp_data_q <= is_wr_q ? 8'h00 : db_i;
                        astb_q     <= STB_IDLE;
                        dstb_q     <= STB_IDLE;
`ifdef EPP_HOST_TIMEOUT_EN
                        to_cnt_q   <= '0;
`endif
                        state_q    <= ST_RELEASE;
                    end
`ifdef EPP_HOST_TIMEOUT_EN
                    else if (to_cnt_q == TO_LAST) begin
                        astb_q        <= STB_IDLE;
                        dstb_q        <= STB_IDLE;
                        eppwr_q       <= WR_IDLE;
                        db_oe_q       <= 1'b0;
                        db_o_q        <= '0;
                        rsp_valid_q   <= 1'b1;
                        rsp_timeout_q <= 1'b1;
                        rsp_data_q    <= '0;
                        state_q       <= ST_ABORT;
                    end else begin
                        to_cnt_q <= to_cnt_q + 1'b1;
                    end
`endif
                end

                // db_oe/EppWr stay put until Wait falls so the peripheral never sees them move early.
                ST_RELEASE: begin
                    if (!wait_s) begin
                        eppwr_q     <= WR_IDLE;
                        db_oe_q     <= 1'b0;
                        db_o_q      <= '0;
                        rsp_valid_q <= 1'b1;
                        state_q     <= ST_DONE;
                    end
`ifdef EPP_HOST_TIMEOUT_EN
                    else if (to_cnt_q == TO_LAST) begin
                        eppwr_q       <= WR_IDLE;
                        db_oe_q       <= 1'b0;
                        db_o_q        <= '0;
                        rsp_valid_q   <= 1'b1;
                        rsp_timeout_q <= 1'b1;
                        rsp_data_q    <= '0;
                        state_q       <= ST_ABORT;
                    end else begin
                        to_cnt_q <= to_cnt_q + 1'b1;
                    end
`endif
                end

                ST_DONE: begin
                    rsp_valid_q <= 1'b0;
                    cmd_ready_q <= 1'b1;
                    state_q     <= ST_IDLE;
                end

`ifdef EPP_HOST_TIMEOUT_EN
                ST_ABORT: begin
                    rsp_valid_q   <= 1'b0;
                    rsp_timeout_q <= 1'b0;
                    cmd_ready_q   <= 1'b1;
                    state_q       <= ST_IDLE;
                end
`endif

                default: begin
                    astb_q      <= STB_IDLE;
                    dstb_q      <= STB_IDLE;
                    eppwr_q     <= WR_IDLE;
                    db_oe_q     <= 1'b0;
                    rsp_valid_q <= 1'b0;
                    cmd_ready_q <= 1'b1;
                    state_q     <= ST_IDLE;
                end
            endcase
        end
    end

    assign cmd_ready = cmd_ready_q;
    assign EppAstb   = astb_q;
    assign EppDstb   = dstb_q;
    assign EppWr     = eppwr_q;
    assign db_o      = db_o_q;
    assign db_oe     = db_oe_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;

`ifdef EPP_HOST_TIMEOUT_EN
    assign rsp_timeout = rsp_timeout_q;
`else
    assign rsp_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_epp_host.sv
// Bench for epp_host: EPP peripheral model with configurable Wait delays and a response scoreboard.
module tb_epp_host;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic       cmd_addr = 1'b0;
    logic       cmd_wr = 1'b0;
    logic [7:0] cmd_data = 8'h00;
    logic       rsp_valid;
    logic [7:0] rsp_data;
    logic       rsp_timeout;
    logic       EppAstb;
    logic       EppDstb;
    logic       EppWr;
    logic       EppWait = 1'b0;
    logic [7:0] db_o;
    logic       db_oe;
    logic [7:0] db_i = 8'hEE;

    always #5 clk = ~clk;

    epp_host #(
        .SETUP_CYC   (2),
        .TIMEOUT_CYC (15)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_addr    (cmd_addr),
        .cmd_wr      (cmd_wr),
        .cmd_data    (cmd_data),
        .rsp_valid   (rsp_valid),
        .rsp_data    (rsp_data),
        .rsp_timeout (rsp_timeout),
        .EppAstb     (EppAstb),
        .EppDstb     (EppDstb),
        .EppWr       (EppWr),
        .EppWait     (EppWait),
        .db_o        (db_o),
        .db_oe       (db_oe),
        .db_i        (db_i)
    );

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;
    int rsp_cyc = 0;
    int rsp_seen = 0;

    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [7:0] data;
        logic       to;
    } exp_t;
    exp_t sb[$];

    logic [7:0] model_mem[256];
    logic [7:0] model_addr = 8'h00;
    logic [7:0] per_mem[256];
    logic [7:0] per_addr = 8'h00;
    logic [7:0] per_wlog[$];

    int p_rise = 1;
    int p_fall = 1;
    bit rand_dly = 1'b0;
    bit periph_en = 1'b1;

    // Scoreboard and bus-protocol monitor, sampled mid-cycle.
    always @(negedge clk) begin
        exp_t e;
        if (rsp_valid === 1'b1) begin
            vectors++;
            rsp_seen++;
            rsp_cyc = cyc;
            if (sb.size() == 0) begin
                miscompares++;
                $display("FAIL rsp_unexpected: rsp_valid=1 data=%h to=%b, required no response", rsp_data, rsp_timeout);
            end else begin
                e = sb.pop_front();
                if (rsp_data !== e.data || rsp_timeout !== e.to) begin
                    miscompares++;
                    $display("FAIL rsp_check: got data=%h to=%b, required data=%h to=%b", rsp_data, rsp_timeout, e.data, e.to);
                end
            end
        end
        vectors++;
        if (EppAstb === 1'b0 && EppDstb === 1'b0) begin
            miscompares++;
            $display("FAIL both_strobes: EppAstb=%b EppDstb=%b at cycle %0d, required not both 0", EppAstb, EppDstb, cyc);
        end
    end

    // Peripheral: captures on strobe fall, raises Wait after p_rise, drops it p_fall after strobe rise.
    initial begin
        int dr;
        int df;
        bit is_a;
        forever begin
            @(posedge clk); #1;
            if (periph_en && rst_n === 1'b1 && (EppAstb === 1'b0 || EppDstb === 1'b0)) begin
                is_a = (EppAstb === 1'b0);
                dr = rand_dly ? int'($urandom_range(0, 5)) : p_rise;
                df = rand_dly ? int'($urandom_range(0, 5)) : p_fall;
                if (EppWr === 1'b0) begin
                    if (is_a) per_addr = db_o;
                    else begin
                        per_mem[per_addr] = db_o;
                        per_wlog.push_back(db_o);
                    end
                end else begin
                    db_i = is_a ? per_addr : per_mem[per_addr];
                end
                if (dr > 0) begin
                    repeat (dr) @(posedge clk);
                    #1;
                end
                EppWait = 1'b1;
                for (int c = 0; c < 100 && (EppAstb === 1'b0 || EppDstb === 1'b0); c++) begin
                    @(posedge clk); #1;
                end
                if (df > 0) begin
                    repeat (df) @(posedge clk);
                    #1;
                end
                EppWait = 1'b0;
                db_i = 8'hEE;
            end
        end
    end

    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic issue(input logic a, input logic w, input logic [7:0] d, input logic exp_to, output int k);
        exp_t e;
        for (int c = 0; c < 200 && cmd_ready !== 1'b1; c++) step();
        if (cmd_ready !== 1'b1) begin
            vectors++;
            miscompares++;
            $display("FAIL issue_ready: cmd_ready=%b after 200 cycles, required 1", cmd_ready);
            k = -1;
            return;
        end
        e.to = exp_to;
        if (exp_to) e.data = 8'h00;
        else if (w) begin
            e.data = 8'h00;
            if (a) model_addr = d;
            else model_mem[model_addr] = d;
        end else begin
            e.data = a ? model_addr : model_mem[model_addr];
        end
        sb.push_back(e);
        cmd_valid = 1'b1;
        cmd_addr = a;
        cmd_wr = w;
        cmd_data = d;
        step();
        k = cyc;
        cmd_valid = 1'b0;
        cmd_data = 8'($urandom);
    endtask

    task automatic wait_idle(input int budget);
        for (int c = 0; c < budget && !(sb.size() == 0 && cmd_ready === 1'b1); c++) step();
        if (sb.size() != 0 || cmd_ready !== 1'b1) begin
            vectors++;
            miscompares++;
            $display("FAIL wait_idle: pending=%0d cmd_ready=%b after %0d cycles, required 0 and 1", sb.size(), cmd_ready, budget);
            sb.delete();
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        vectors++;
        if ({EppAstb, EppDstb, EppWr, db_oe, db_o, rsp_valid, rsp_data, rsp_timeout, cmd_ready} !== {4'b1110, 8'h00, 1'b0, 8'h00, 2'b01}) begin
            miscompares++;
            $display("FAIL reset_in: got %h, required %h", {EppAstb, EppDstb, EppWr, db_oe, db_o, rsp_valid, rsp_data, rsp_timeout, cmd_ready}, {4'b1110, 8'h00, 1'b0, 8'h00, 2'b01});
        end
        #2 rst_n = 1'b1;
        repeat (2) step();
        vectors++;
        if ({EppAstb, EppDstb, EppWr, db_oe, db_o, rsp_valid, rsp_data, rsp_timeout, cmd_ready} !== {4'b1110, 8'h00, 1'b0, 8'h00, 2'b01}) begin
            miscompares++;
            $display("FAIL reset_out: got %h, required %h", {EppAstb, EppDstb, EppWr, db_oe, db_o, rsp_valid, rsp_data, rsp_timeout, cmd_ready}, {4'b1110, 8'h00, 1'b0, 8'h00, 2'b01});
        end
    endtask

    task automatic test_addr_write();
        int k;
        issue(1'b1, 1'b1, 8'h3A, 1'b0, k);
        for (int j = 1; j <= 2; j++) begin
            step();
            vectors++;
            if ({EppWr, db_oe, db_o, EppAstb, EppDstb} !== {2'b01, 8'h3A, 2'b11}) begin
                miscompares++;
                $display("FAIL setup_k%0d: got wr/oe/db/astb/dstb=%h, required %h", j, {EppWr, db_oe, db_o, EppAstb, EppDstb}, {2'b01, 8'h3A, 2'b11});
            end
        end
        step();
        vectors++;
        if ({EppAstb, EppDstb, EppWr, db_oe, db_o} !== {4'b0101, 8'h3A}) begin
            miscompares++;
            $display("FAIL strobe_k3: got astb/dstb/wr/oe/db=%h, required %h", {EppAstb, EppDstb, EppWr, db_oe, db_o}, {4'b0101, 8'h3A});
        end
        wait_idle(60);
        vectors++;
        if (rsp_cyc !== k + 11) begin
            miscompares++;
            $display("FAIL rsp_latency: got cycle %0d, required %0d", rsp_cyc, k + 11);
        end
        vectors++;
        if (per_addr !== 8'h3A) begin
            miscompares++;
            $display("FAIL periph_addr: got %h, required 3a", per_addr);
        end
    endtask

    task automatic test_data_read();
        int k;
        int bad;
        issue(1'b1, 1'b1, 8'h10, 1'b0, k);
        wait_idle(60);
        per_mem[8'h10] = 8'hC5;
        model_mem[8'h10] = 8'hC5;
        issue(1'b0, 1'b0, 8'h5F, 1'b0, k);
        bad = 0;
        for (int c = 0; c < 60 && !(sb.size() == 0 && cmd_ready === 1'b1); c++) begin
            if (db_oe !== 1'b0 || EppWr !== 1'b1) bad++;
            step();
        end
        vectors++;
        if (bad != 0) begin
            miscompares++;
            $display("FAIL read_bus: %0d cycles with db_oe=1 or EppWr=0, required 0", bad);
        end
        wait_idle(10);
    endtask

    task automatic test_back_to_back();
        int k;
        int n;
        logic [7:0] vals[2];
        exp_t e;
        vals[0] = 8'h11;
        vals[1] = 8'h22;
        issue(1'b1, 1'b1, 8'h20, 1'b0, k);
        wait_idle(60);
        per_wlog.delete();
        n = 0;
        cmd_valid = 1'b1;
        cmd_addr = 1'b0;
        cmd_wr = 1'b1;
        for (int c = 0; c < 80 && n < 2; c++) begin
            if (cmd_ready === 1'b1) begin
                cmd_data = vals[n];
                model_mem[model_addr] = vals[n];
                e.data = 8'h00;
                e.to = 1'b0;
                sb.push_back(e);
                n++;
            end else begin
                cmd_data = 8'($urandom);
            end
            step();
        end
        cmd_valid = 1'b0;
        wait_idle(60);
        vectors++;
        if (n != 2 || per_wlog.size() != 2) begin
            miscompares++;
            $display("FAIL b2b_count: accepted %0d, handshakes %0d, required 2 and 2", n, per_wlog.size());
        end else begin
            vectors++;
            if (per_wlog[0] !== 8'h11 || per_wlog[1] !== 8'h22) begin
                miscompares++;
                $display("FAIL b2b_data: got %h %h, required 11 22", per_wlog[0], per_wlog[1]);
            end
        end
    endtask

    task automatic test_no_wait();
        int k;
        periph_en = 1'b0;
`ifdef EPP_HOST_TIMEOUT_EN
        begin
            int low;
            issue(1'b0, 1'b0, 8'h00, 1'b1, k);
            low = 0;
            for (int c = 0; c < 60 && !(sb.size() == 0 && cmd_ready === 1'b1); c++) begin
                if (EppDstb === 1'b0) low++;
                step();
            end
            vectors++;
            if (low != 15) begin
                miscompares++;
                $display("FAIL timeout_len: strobe low %0d cycles, required 15", low);
            end
            wait_idle(10);
            periph_en = 1'b1;
        end
`else
        issue(1'b0, 1'b0, 8'h00, 1'b0, k);
        repeat (60) step();
        vectors++;
        if (sb.size() != 1 || EppDstb !== 1'b0 || rsp_timeout !== 1'b0) begin
            miscompares++;
            $display("FAIL no_wait_hold: pending=%0d dstb=%b to=%b, required 1 0 0", sb.size(), EppDstb, rsp_timeout);
        end
        periph_en = 1'b1;
        wait_idle(60);
`endif
    endtask

    task automatic test_reset_mid();
        int k;
        int seen0;
        issue(1'b0, 1'b1, 8'h77, 1'b0, k);
        for (int c = 0; c < 20 && EppDstb !== 1'b0; c++) step();
        #2 rst_n = 1'b0;
        #1;
        vectors++;
        if ({EppAstb, EppDstb, db_oe, EppWr} !== 4'b1101) begin
            miscompares++;
            $display("FAIL reset_async: got astb/dstb/oe/wr=%b, required 1101", {EppAstb, EppDstb, db_oe, EppWr});
        end
        sb.delete();
        seen0 = rsp_seen;
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b1;
        step();
        for (int c = 0; c < 20 && EppWait !== 1'b0; c++) step();
        repeat (4) step();
        vectors++;
        if (rsp_seen != seen0) begin
            miscompares++;
            $display("FAIL reset_rsp: %0d responses after reset, required 0", rsp_seen - seen0);
        end
        issue(1'b0, 1'b0, 8'h00, 1'b0, k);
        wait_idle(60);
    endtask

    task automatic test_random();
        int k;
        int op;
        int bad;
        rand_dly = 1'b1;
        for (int t = 0; t < 100; t++) begin
            op = int'($urandom_range(0, 3));
            case (op)
                0: issue(1'b1, 1'b1, 8'($urandom_range(0, 15)), 1'b0, k);
                1: issue(1'b0, 1'b1, 8'($urandom), 1'b0, k);
                2: issue(1'b0, 1'b0, 8'($urandom), 1'b0, k);
                default: issue(1'b1, 1'b0, 8'($urandom), 1'b0, k);
            endcase
            wait_idle(100);
        end
        rand_dly = 1'b0;
        bad = 0;
        for (int i = 0; i < 256; i++) if (per_mem[i] !== model_mem[i]) bad++;
        vectors++;
        if (bad != 0) begin
            miscompares++;
            $display("FAIL mem_final: %0d locations differ from model, required 0", bad);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 256; i++) begin
            per_mem[i] = 8'(i) ^ 8'h5A;
            model_mem[i] = 8'(i) ^ 8'h5A;
        end
        test_reset();
        test_addr_write();
        test_data_read();
        test_back_to_back();
        test_no_wait();
        test_reset_mid();
        test_random();
        repeat (3) step();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
